// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//   Pipeline hazard/redirect scheduler for the 19-bit-instruction five-stage core.
//   Tracks the writers in EX and MEM, stalls the ID instruction on register
//   RAW or flag hazards, accepts Controller redirects and squashes the
//   wrong-path ID slots that follow. It also keeps saturating stall/flush counters.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   id_valid   ID holds a real instruction
//   id_instr   instruction in ID
//   pc_mux     Controller PC select; nonzero means redirect
//   stall      hold PC and IF/ID this cycle (combinational)
//   bubble_ex  load a NOP into ID/EX this cycle (combinational)
//   flush_if   clear IF/ID at next edge (combinational)
//   squash_id  ID instruction is wrong-path (combinational from state)
//   stall_cnt  stall cycles, saturating
//   flush_cnt  accepted redirects, saturating
module hazard_scheduler #(
    parameter int unsigned INSTR_W      = 19,
    parameter int unsigned REG_AW       = 3,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned R0_ZERO      = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic [1:0]         pc_mux,
    output logic               stall,
    output logic               bubble_ex,
    output logic               flush_if,
    output logic               squash_id,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int unsigned OP_W   = 5;
    localparam int unsigned SQ_W   = 3;
    localparam int unsigned RD_LSB = 11;
    localparam int unsigned RS_LSB = 8;
    localparam int unsigned RT_LSB = 5;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              wf;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [SQ_W-1:0]   sq;
    sb_entry_t         sb_ex;
    sb_entry_t         sb_mem;

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs;
    logic [REG_AW-1:0] f_rt;
    logic              d_wr;
    logic              d_wf;
    logic              use_rs;
    logic              use_rt;
    logic              use_rd;
    logic              use_fl;
    logic              raw;
    logic              flag_hz;
    logic              eff_valid;
    sb_entry_t         dec;

    assign op   = id_instr[INSTR_W-1 -: OP_W];
    assign f_rd = id_instr[RD_LSB +: REG_AW];
    assign f_rs = id_instr[RS_LSB +: REG_AW];
    assign f_rt = id_instr[RT_LSB +: REG_AW];

    // Instruction class decode: which registers/flags ID reads and writes.
    always_comb begin
        d_wr   = 1'b0;
        d_wf   = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        use_fl = 1'b0;
        if (!op[4]) begin
            // ALU: op[3] set selects the immediate form, which has no rt read.
            d_wr   = 1'b1;
            d_wf   = 1'b1;
            use_rs = 1'b1;
            use_rt = ~op[3];
        end else begin
            case (op[3:2])
                2'b00: begin
                    use_rs = 1'b1;
                    if (op[0]) begin
                        use_rd = 1'b1;          // STM reads its data register
                    end else begin
                        d_wr = 1'b1;            // LDM
                    end
                end
                2'b01: use_fl = 1'b1;           // branch
                2'b10: begin                    // shift
                    d_wr   = 1'b1;
                    d_wf   = 1'b1;
                    use_rs = 1'b1;
                end
                default: ;                      // JMP/JSB/RET: no register hazards
            endcase
        end
    end

    // A scoreboard entry matches a source when it is a live register writer.
    function automatic logic hits(input sb_entry_t e, input logic [REG_AW-1:0] r);
        logic r0_free;
        r0_free = (R0_ZERO != 0) && (e.rd == '0);
        return e.v & e.wr & (e.rd == r) & ~r0_free;
    endfunction

    always_comb begin
        raw = (use_rs & (hits(sb_ex, f_rs) | hits(sb_mem, f_rs))) |
              (use_rt & (hits(sb_ex, f_rt) | hits(sb_mem, f_rt))) |
              (use_rd & (hits(sb_ex, f_rd) | hits(sb_mem, f_rd)));
        // Flags are produced at the end of EX, so only an EX flag writer blocks.
        flag_hz = use_fl & sb_ex.v & sb_ex.wf;
    end

    // Hazard outputs; everything is forced low while reset is held.
    always_comb begin
        squash_id = reset & (state == ST_FLUSH);
        eff_valid = reset & id_valid & ~squash_id;
        stall     = eff_valid & (raw | flag_hz);
        bubble_ex = stall | squash_id;
        flush_if  = eff_valid & ~stall & (pc_mux != 2'b00);
    end

    always_comb begin
        dec    = '0;
        dec.v  = 1'b1;
        dec.rd = f_rd;
        dec.wr = d_wr;
        dec.wf = d_wf;
    end

    // EX/MEM writer scoreboard; stalled or squashed slots enter EX as empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_ex  <= '0;
            sb_mem <= '0;
        end else begin
            sb_mem <= sb_ex;
            sb_ex  <= (id_valid & ~stall & ~squash_id) ? dec : '0;
        end
    end

    // Sequencing FSM with wrong-path squash counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            sq    <= '0;
        end else begin
            case (state)
                ST_RUN, ST_STALL: begin
                    if (stall) begin
                        state <= ST_STALL;
                    end else if (flush_if) begin
                        state <= ST_FLUSH;
                        sq    <= SQ_W'(FLUSH_CYCLES);
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    sq <= sq - SQ_W'(1);
                    if (sq == SQ_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_if && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Immediate/function bits and the MEM flag bit play no part in hazards.
    logic unused_bits;
    assign unused_bits = ^{id_instr[RT_LSB-1:0], sb_mem.wf};

endmodule
